comp_decision_filter: RTL and testbench

//  Stage directly downstream of the N-bit Comparator. Consumes its three result flags
//  (equal / A_greater_than_B / B_greater_than_A) under a valid/ready handshake.

---
 rtl/comp_pkg.sv | 24 ++
 rtl/comp_decision_filter.sv | 98 +++++++++
 tb/tb_comp_decision_filter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comp_pkg.sv
// Shared comparator result encoding and flag decoding, used by the decision
// filter and the comparator bench.
package comp_pkg;

   typedef enum logic [1:0] {
      RES_UNKNOWN = 2'd0,
      RES_EQ      = 2'd1,
      RES_AGT     = 2'd2,
      RES_BGT     = 2'd3
   } res_t;

   // Returns {illegal, relation}; anything but exactly one flag high is illegal.
   function automatic logic [2:0] decode_flags(input logic eq, input logic agt, input logic bgt);
      logic [2:0] result;
      case ({eq, agt, bgt})
         3'b100:  result = {1'b0, RES_EQ};
         3'b010:  result = {1'b0, RES_AGT};
         3'b001:  result = {1'b0, RES_BGT};
         default: result = {1'b1, RES_UNKNOWN};
      endcase
      return result;
   endfunction

endpackage

// File: rtl/comp_decision_filter.sv
// Debounces comparator result flags: a relation is committed after CONFIRM
// consecutive identical accepted samples, and each commit becomes a buffered event.
module comp_decision_filter
   import comp_pkg::*;
#(
   parameter int CONFIRM = 3,
   parameter int CW      = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          equal,
   input  logic          A_greater_than_B,
   input  logic          B_greater_than_A,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [1:0]    out_state,
   output logic [1:0]    state_o,
   output logic [CW-1:0] change_cnt,
   output logic          err
);

   localparam int RW = $clog2(CONFIRM + 1);

   res_t          state;
   res_t          cand;
   res_t          evt_state;
   res_t          rel;
   logic [RW-1:0] run;
   logic [RW-1:0] run_inc;
   logic [2:0]    decoded;
   logic          illegal;
   logic          accept;
   logic          commit;

   assign decoded   = decode_flags(equal, A_greater_than_B, B_greater_than_A);
   assign illegal   = decoded[2];
   assign rel       = res_t'(decoded[1:0]);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign run_inc   = run + 1'b1;
   assign state_o   = state;
   assign out_state = evt_state;

   // A sample matching the candidate extends the run; a fresh relation starts a run of one.
   always_comb begin
      commit = 1'b0;
      if (accept && !illegal && (rel != state)) begin
         if (rel == cand)
            commit = (run_inc == RW'(CONFIRM));
         else
            commit = (CONFIRM == 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RES_UNKNOWN;
         cand       <= RES_UNKNOWN;
         run        <= '0;
         change_cnt <= '0;
         err        <= 1'b0;
      end else begin
         err <= accept && illegal;
         if (accept) begin
            if (illegal || commit || (rel == state)) begin
               run  <= '0;
               cand <= RES_UNKNOWN;
            end else if (rel == cand) begin
               run <= run_inc;
            end else begin
               cand <= rel;
               run  <= RW'(1);
            end
            if (commit) begin
               state <= rel;
               if (change_cnt != {CW{1'b1}})
                  change_cnt <= change_cnt + 1'b1;
            end
         end
      end
   end

   // A new commit takes priority over draining, so a simultaneous handshake reloads the buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         evt_state <= RES_UNKNOWN;
      end else if (commit) begin
         out_valid <= 1'b1;
         evt_state <= rel;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_comp_decision_filter.sv
// Randomized and directed bench for comp_decision_filter: dut (CONFIRM=3, CW=8)
// and dut2 (CONFIRM=1, CW=2) share stimulus and are compared to a streak model.
module tb_comp_decision_filter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       eq = 1'b0;
   logic       agt = 1'b0;
   logic       bgt = 1'b0;
   logic       out_ready = 1'b1;

   logic       in_ready, out_valid, err;
   logic [1:0] out_state, state_o;
   logic [7:0] change_cnt;
   logic       in_ready2, out_valid2, err2;
   logic [1:0] out_state2, state_o2;
   logic [1:0] change_cnt2;

   int total = 0;
   int bad = 0;

   logic       m_ov [2];
   logic       m_err [2];
   logic [1:0] m_os [2];
   logic [1:0] m_state [2];
   logic [1:0] m_rel [2];
   int         m_streak [2];
   int         m_cnt [2];

   always #5 clk = ~clk;

   comp_decision_filter #(.CONFIRM(3), .CW(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .equal(eq), .A_greater_than_B(agt), .B_greater_than_A(bgt),
      .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
      .state_o(state_o), .change_cnt(change_cnt), .err(err)
   );

   comp_decision_filter #(.CONFIRM(1), .CW(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .equal(eq), .A_greater_than_B(agt), .B_greater_than_A(bgt),
      .out_valid(out_valid2), .out_ready(out_ready), .out_state(out_state2),
      .state_o(state_o2), .change_cnt(change_cnt2), .err(err2)
   );

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_ov[i] = 1'b0; m_err[i] = 1'b0; m_os[i] = 2'd0; m_state[i] = 2'd0;
         m_rel[i] = 2'd0; m_streak[i] = 0; m_cnt[i] = 0;
      end
   endtask

   // Commit once the last CONFIRM accepted samples agree and differ from the committed relation.
   task automatic model_edge();
      logic       ill;
      logic       acc;
      logic       com;
      logic [1:0] r;
      int         conf;
      int         sat;
      if (!rst_n) begin
         model_reset();
         return;
      end
      ill = (int'(eq) + int'(agt) + int'(bgt)) != 1;
      r = eq ? 2'd1 : (agt ? 2'd2 : 2'd3);
      for (int i = 0; i < 2; i++) begin
         conf = (i == 0) ? 3 : 1;
         sat = (i == 0) ? 255 : 3;
         acc = in_valid && (!m_ov[i] || out_ready);
         com = 1'b0;
         m_err[i] = acc && ill;
         if (acc && ill) begin
            m_streak[i] = 0;
         end else if (acc) begin
            if (r == m_state[i]) begin
               m_streak[i] = 0;
            end else begin
               if (m_streak[i] > 0 && m_rel[i] == r) begin
                  m_streak[i]++;
               end else begin
                  m_rel[i] = r;
                  m_streak[i] = 1;
               end
               com = (m_streak[i] == conf);
            end
         end
         if (com) begin
            m_state[i] = r;
            m_streak[i] = 0;
            m_ov[i] = 1'b1;
            m_os[i] = r;
            if (m_cnt[i] < sat) m_cnt[i]++;
         end else if (m_ov[i] && out_ready) begin
            m_ov[i] = 1'b0;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_ab(input int a, input int b);
      in_valid = 1'b1;
      eq = (a == b);
      agt = (a > b);
      bgt = (a < b);
   endtask

   task automatic rst_pulse();
      #3;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      in_valid = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      out_ready = 1'b0;
      set_ab(9, 3);
      repeat (3) step();
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL pre_reset_valid got=%0d exp=1", out_valid); end
      #3;
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%0d exp=0", out_valid); end
      total++;
      if (state_o !== 2'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d exp=0", state_o); end
      total++;
      if (change_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_cnt got=%0d exp=0", change_cnt); end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%0d exp=1", in_ready); end
      total++;
      if (out_state !== 2'd0) begin bad++; $display("[TB] FAIL reset_out_state got=%0d exp=0", out_state); end
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_commit();
      out_ready = 1'b1;
      set_ab(9, 3);
      step();
      step();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL early_commit got=%0d exp=0", out_valid); end
      step();
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL commit_valid got=%0d exp=1", out_valid); end
      total++;
      if (out_state !== 2'd2) begin bad++; $display("[TB] FAIL commit_out_state got=%0d exp=2", out_state); end
      total++;
      if (state_o !== 2'd2) begin bad++; $display("[TB] FAIL commit_state got=%0d exp=2", state_o); end
      total++;
      if (change_cnt !== 8'd1) begin bad++; $display("[TB] FAIL commit_cnt got=%0d exp=1", change_cnt); end
      in_valid = 1'b0;
      step();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL drain_valid got=%0d exp=0", out_valid); end
   endtask

   task automatic test_debounce();
      int seq [5] = '{2, 2, 1, 2, 2};
      out_ready = 1'b1;
      set_ab(5, 5);
      repeat (3) step();
      total++;
      if (state_o !== 2'd1) begin bad++; $display("[TB] FAIL eq_commit got=%0d exp=1", state_o); end
      for (int k = 0; k < 5; k++) begin
         if (seq[k] == 1) set_ab(5, 5); else set_ab(9, 3);
         step();
      end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL broken_run_event got=%0d exp=0", out_valid); end
      total++;
      if (state_o !== 2'd1) begin bad++; $display("[TB] FAIL broken_run_state got=%0d exp=1", state_o); end
      set_ab(9, 3);
      step();
      total++;
      if (out_valid !== 1'b1 || out_state !== 2'd2) begin
         bad++; $display("[TB] FAIL third_agt_event got=%0d/%0d exp=1/2", out_valid, out_state);
      end
      total++;
      if (change_cnt !== 8'd3) begin bad++; $display("[TB] FAIL debounce_cnt got=%0d exp=3", change_cnt); end
   endtask

   task automatic test_illegal();
      out_ready = 1'b1;
      set_ab(2, 7);
      repeat (2) step();
      eq = 1'b1; agt = 1'b1; bgt = 1'b0;
      step();
      total++;
      if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_pulse got=%0d exp=1", err); end
      total++;
      if (state_o !== 2'd2) begin bad++; $display("[TB] FAIL err_state got=%0d exp=2", state_o); end
      set_ab(2, 7);
      step();
      total++;
      if (err !== 1'b0) begin bad++; $display("[TB] FAIL err_one_cycle got=%0d exp=0", err); end
      step();
      total++;
      if (out_valid !== 1'b0 || state_o !== 2'd2) begin
         bad++; $display("[TB] FAIL run_cleared got=%0d/%0d exp=0/2", out_valid, state_o);
      end
      step();
      total++;
      if (out_valid !== 1'b1 || state_o !== 2'd3 || out_state !== 2'd3) begin
         bad++; $display("[TB] FAIL bgt_commit got=%0d/%0d/%0d exp=1/3/3", out_valid, state_o, out_state);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      set_ab(5, 5);
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready got=%0d exp=0", in_ready); end
      for (int k = 0; k < 10; k++) begin
         step();
         total++;
         if (out_valid !== 1'b1 || out_state !== 2'd3 || in_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL bp_hold cyc=%0d got=%0d/%0d/%0d exp=1/3/0", k, out_valid, out_state, in_ready);
         end
      end
      out_ready = 1'b1;
      in_valid = 1'b0;
      step();
      total++;
      if (out_valid !== 1'b0 || state_o !== 2'd3) begin
         bad++; $display("[TB] FAIL bp_drain got=%0d/%0d exp=0/3", out_valid, state_o);
      end
      set_ab(2, 7);
      step();
      set_ab(5, 5);
      step();
      total++;
      if (out_valid2 !== 1'b1 || out_state2 !== 2'd1) begin
         bad++; $display("[TB] FAIL c1_eq_event got=%0d/%0d exp=1/1", out_valid2, out_state2);
      end
      set_ab(9, 3);
      step();
      total++;
      if (out_valid2 !== 1'b1 || out_state2 !== 2'd2 || state_o2 !== 2'd2) begin
         bad++; $display("[TB] FAIL reload_event got=%0d/%0d/%0d exp=1/2/2", out_valid2, out_state2, state_o2);
      end
   endtask

   task automatic test_saturate_reset();
      rst_pulse();
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k % 2 == 0) set_ab(9, 3); else set_ab(2, 7);
         step();
         if (k == 1) begin
            total++;
            if (change_cnt2 !== 2'd2) begin bad++; $display("[TB] FAIL cnt2_two got=%0d exp=2", change_cnt2); end
         end
      end
      total++;
      if (change_cnt2 !== 2'd3) begin bad++; $display("[TB] FAIL cnt2_saturate got=%0d exp=3", change_cnt2); end
      total++;
      if (out_state2 !== 2'd2) begin bad++; $display("[TB] FAIL cnt2_last_event got=%0d exp=2", out_state2); end
      rst_pulse();
      set_ab(9, 3);
      repeat (2) step();
      rst_pulse();
      repeat (2) step();
      total++;
      if (out_valid !== 1'b0 || state_o !== 2'd0) begin
         bad++; $display("[TB] FAIL post_reset_early got=%0d/%0d exp=0/0", out_valid, state_o);
      end
      step();
      total++;
      if (out_valid !== 1'b1 || state_o !== 2'd2 || change_cnt !== 8'd1) begin
         bad++; $display("[TB] FAIL post_reset_commit got=%0d/%0d/%0d exp=1/2/1", out_valid, state_o, change_cnt);
      end
   endtask

   task automatic test_random();
      int a = 0;
      int b = 0;
      rst_pulse();
      for (int k = 0; k < 400; k++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 3) == 0) begin
            a = $urandom_range(0, 15);
            b = ($urandom_range(0, 2) == 0) ? a : $urandom_range(0, 15);
         end
         eq = (a == b); agt = (a > b); bgt = (a < b);
         if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 4))
               0: {eq, agt, bgt} = 3'b000;
               1: {eq, agt, bgt} = 3'b011;
               2: {eq, agt, bgt} = 3'b101;
               3: {eq, agt, bgt} = 3'b110;
               default: {eq, agt, bgt} = 3'b111;
            endcase
         end
         step();
         total++;
         if (out_valid !== m_ov[0] || out_state !== m_os[0] || state_o !== m_state[0] ||
             change_cnt !== 8'(m_cnt[0]) || err !== m_err[0] || in_ready !== (!m_ov[0] || out_ready)) begin
            bad++;
            $display("[TB] FAIL rand_c3 cyc=%0d got v%0d s%0d st%0d c%0d e%0d r%0d exp v%0d s%0d st%0d c%0d e%0d",
                     k, out_valid, out_state, state_o, change_cnt, err, in_ready,
                     m_ov[0], m_os[0], m_state[0], m_cnt[0], m_err[0]);
         end
         total++;
         if (out_valid2 !== m_ov[1] || out_state2 !== m_os[1] || state_o2 !== m_state[1] ||
             change_cnt2 !== 2'(m_cnt[1]) || err2 !== m_err[1] || in_ready2 !== (!m_ov[1] || out_ready)) begin
            bad++;
            $display("[TB] FAIL rand_c1 cyc=%0d got v%0d s%0d st%0d c%0d e%0d r%0d exp v%0d s%0d st%0d c%0d e%0d",
                     k, out_valid2, out_state2, state_o2, change_cnt2, err2, in_ready2,
                     m_ov[1], m_os[1], m_state[1], m_cnt[1], m_err[1]);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_commit();
      test_debounce();
      test_illegal();
      test_backpressure();
      test_saturate_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
